// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 serial front-ends.
// Register addresses occupy bits [11:8] of each 16-bit device word.
package max7219_pkg;

  localparam int          C_MAX7219_WORD_W = 16;
  localparam logic [15:0] C_MAX7219_NOOP   = 16'h0000;

  localparam logic [3:0] C_REG_NOOP       = 4'h0;
  localparam logic [3:0] C_REG_DIGIT0     = 4'h1;
  localparam logic [3:0] C_REG_DIGIT1     = 4'h2;
  localparam logic [3:0] C_REG_DIGIT2     = 4'h3;
  localparam logic [3:0] C_REG_DIGIT3     = 4'h4;
  localparam logic [3:0] C_REG_DIGIT4     = 4'h5;
  localparam logic [3:0] C_REG_DIGIT5     = 4'h6;
  localparam logic [3:0] C_REG_DIGIT6     = 4'h7;
  localparam logic [3:0] C_REG_DIGIT7     = 4'h8;
  localparam logic [3:0] C_REG_DECODE     = 4'h9;
  localparam logic [3:0] C_REG_INTENSITY  = 4'hA;
  localparam logic [3:0] C_REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] C_REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] C_REG_TEST       = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/max7219_bit_timer.sv
// Half-period counter for the serial clock. rise_tick marks the last cycle of
// the low half, bit_tick the last cycle of the high half (end of a bit).
module max7219_bit_timer #(
  parameter int G_MAX_HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_tick,
  output logic bit_tick
);

  localparam int CW = (G_MAX_HALF_PERIOD > 1) ? $clog2(G_MAX_HALF_PERIOD) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(G_MAX_HALF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          high;
  logic          wrap;

  assign wrap = en && (cnt == C_LAST);

  // Held cleared while disabled so every frame starts on a fresh low half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      high <= ~high;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise_tick = wrap & ~high;
  assign bit_tick  = wrap & high;

endmodule

// File: rtl/max7219_chain_if.sv
// Shifts a whole daisy-chain frame (one word per device, MSB of the frame
// first) and optionally pulses LOAD so all devices latch together.
module max7219_chain_if
  import max7219_pkg::*;
#(
  parameter int G_NB_MATRIX       = 8,
  parameter int G_MAX_HALF_PERIOD = 4,
  parameter int G_LOAD_DURATION   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_en_load,
  input  logic [16*G_NB_MATRIX-1:0]       i_data,
  input  logic [G_NB_MATRIX-1:0]          i_mask,
  output logic                            o_max7219_clk,
  output logic                            o_max7219_data,
  output logic                            o_max7219_load,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int FW = C_MAX7219_WORD_W * G_NB_MATRIX;
  localparam int BW = $clog2(FW + 1);
  localparam int LW = $clog2(G_LOAD_DURATION + 1);
  localparam logic [BW-1:0] C_LAST_BIT  = BW'(FW - 1);
  localparam logic [LW-1:0] C_LAST_LOAD = LW'(G_LOAD_DURATION - 1);

  state_t        state, state_nxt;
  logic [FW-1:0] sreg, frame_masked;
  logic [BW-1:0] bit_cnt;
  logic [LW-1:0] load_cnt;
  logic          en_load_q, clk_q;
  logic          accept, shifting, rise_tick, bit_tick, last_bit, load_end;

  always_comb begin
    frame_masked = '0;
    for (int k = 0; k < G_NB_MATRIX; k++) begin
      frame_masked[16*k +: 16] = i_mask[k] ? i_data[16*k +: 16] : C_MAX7219_NOOP;
    end
  end

  // Starts are honoured in IDLE and in the DONE cycle (back-to-back frames).
  assign accept   = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign shifting = (state == ST_SHIFT);
  assign last_bit = (bit_cnt == C_LAST_BIT);
  assign load_end = (load_cnt == C_LAST_LOAD);

  max7219_bit_timer #(
    .G_MAX_HALF_PERIOD(G_MAX_HALF_PERIOD)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shifting),
    .rise_tick(rise_tick),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_tick && last_bit) state_nxt = en_load_q ? ST_LOAD : ST_DONE;
      ST_LOAD:  if (load_end) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = accept ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      en_load_q <= 1'b0;
      clk_q     <= 1'b0;
      load_cnt  <= '0;
    end else begin
      if (accept) begin
        sreg      <= frame_masked;
        bit_cnt   <= '0;
        en_load_q <= i_en_load;
      end else if (shifting && bit_tick) begin
        sreg    <= {sreg[FW-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rise_tick)                  clk_q <= 1'b1;
      else if (bit_tick || !shifting) clk_q <= 1'b0;
      if (state == ST_LOAD) load_cnt <= load_cnt + 1'b1;
      else                  load_cnt <= '0;
    end
  end

  always_comb begin
    o_busy         = shifting || (state == ST_LOAD);
    o_done         = (state == ST_DONE);
    o_max7219_load = (state == ST_LOAD);
    o_max7219_clk  = clk_q;
    o_max7219_data = shifting & sreg[FW-1];
  end

endmodule
